// File: rtl/dispatch_pkg.sv
// Shared types and constants for the op dispatch sequencer and related bus FSMs.
package dispatch_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StLatch  = 4'd2,
    StDecode = 4'd3,
    StStart  = 4'd4,
    StWait   = 4'd5,
    StNext   = 4'd6,
    StHalt   = 4'd7,
    StFault  = 4'd8
  } state_e;

  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

endpackage

// File: rtl/dispatch_timeout_ctr.sv
// Cycle counter with clear/enable that flags when the count equals TIMEOUT.
module dispatch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] count_o,
  output logic       hit_o
);

  localparam logic [7:0] Limit = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign hit_o   = (cnt_q == Limit);

endmodule

// File: rtl/op_dispatch_fsm.sv
// Instruction fetch/decode/dispatch sequencer driving start/done operation units.
// Optional DISPATCH_PERF_EN adds retired-instruction and worst-stall counters.
module op_dispatch_fsm
  import dispatch_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned PC_W      = 8,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned TIMEOUT   = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_i,
  output logic                 mem_rd_o,
  output logic [PC_W-1:0]      mem_addr_o,
  input  logic [INSTR_W-1:0]   mem_data_i,
  output logic [INSTR_W-1:0]   ir_o,
  output logic [NUM_UNITS-1:0] unit_start_o,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  input  logic [NUM_UNITS-1:0] pc_inc_i,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic                 fault_o,
  output logic [1:0]           fault_code_o
`ifdef DISPATCH_PERF_EN
  ,
  output logic [15:0]          retired_cnt_o,
  output logic [7:0]           stall_max_o
`endif
);

  localparam int unsigned SelW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic                inc_seen_q, inc_seen_d;
  logic [1:0]          fault_code_q, fault_code_d;

  logic [3:0]          op;
  logic                done_sel, inc_sel;
  logic                ctr_clr, ctr_en, ctr_hit;
  logic [7:0]          ctr_count;

  assign op       = ir_q[INSTR_W-1 -: 4];
  assign done_sel = unit_done_i[sel_q];
  assign inc_sel  = pc_inc_i[sel_q];

  dispatch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (ctr_clr),
    .en_i   (ctr_en),
    .count_o(ctr_count),
    .hit_o  (ctr_hit)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    sel_d        = sel_q;
    inc_seen_d   = inc_seen_q;
    fault_code_d = fault_code_q;
    mem_rd_o     = 1'b0;
    unit_start_o = '0;
    ctr_clr      = 1'b0;
    ctr_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        mem_rd_o = 1'b1;
        state_d  = StLatch;
      end
      StLatch: begin
        ir_d    = mem_data_i;
        state_d = StDecode;
      end
      StDecode: begin
        if (32'(op) < NUM_UNITS) begin
          sel_d   = SelW'(op);
          state_d = StStart;
        end else if (op == OP_HALT) begin
          state_d = StHalt;
        end else begin
          fault_code_d = FC_ILLEGAL;
          state_d      = StFault;
        end
      end
      StStart: begin
        unit_start_o[sel_q] = 1'b1;
        ctr_clr             = 1'b1;
        inc_seen_d          = 1'b0;
        state_d             = StWait;
      end
      StWait: begin
        ctr_en = 1'b1;
        // Exactly one PC step per instruction, whichever of pc_inc/done arrives first.
        if ((inc_sel || done_sel) && !inc_seen_q) begin
          pc_d       = pc_q + PC_W'(1);
          inc_seen_d = 1'b1;
        end
        if (done_sel) begin
          state_d = StNext;
        end else if (ctr_hit) begin
          fault_code_d = FC_TIMEOUT;
          state_d      = StFault;
        end
      end
      StNext: begin
        state_d = run_i ? StFetch : StIdle;
      end
      StHalt, StFault: begin
        state_d = state_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= '0;
      sel_q        <= '0;
      inc_seen_q   <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      sel_q        <= sel_d;
      inc_seen_q   <= inc_seen_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign mem_addr_o   = pc_q;
  assign ir_o         = ir_q;
  assign busy_o       = !((state_q == StIdle) || (state_q == StHalt) || (state_q == StFault));
  assign halted_o     = (state_q == StHalt);
  assign fault_o      = (state_q == StFault);
  assign fault_code_o = fault_code_q;

`ifdef DISPATCH_PERF_EN
  logic [15:0] retired_q, retired_d;
  logic [7:0]  stall_max_q, stall_max_d;

  always_comb begin
    retired_d   = retired_q;
    stall_max_d = stall_max_q;
    if ((state_q == StWait) && done_sel) begin
      if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
      if (ctr_count > stall_max_q) stall_max_d = ctr_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_q   <= 16'd0;
      stall_max_q <= 8'd0;
    end else begin
      retired_q   <= retired_d;
      stall_max_q <= stall_max_d;
    end
  end

  assign retired_cnt_o = retired_q;
  assign stall_max_o   = stall_max_q;
`else
  logic unused_ctr_count;
  assign unused_ctr_count = ^ctr_count;
`endif

endmodule

// File: tb/tb_op_dispatch_fsm.sv
// Directed self-checking bench for op_dispatch_fsm with a program memory and unit model.
module tb_op_dispatch_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic [3:0]  unit_start;
  logic [3:0]  unit_done;
  logic [3:0]  pc_inc;
  logic        busy, halted, fault;
  logic [1:0]  fault_code;
`ifdef DISPATCH_PERF_EN
  logic [15:0] retired_cnt;
  logic [7:0]  stall_max;
`endif

  always #5 clk = ~clk;

  op_dispatch_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .run_i       (run),
    .mem_rd_o    (mem_rd),
    .mem_addr_o  (mem_addr),
    .mem_data_i  (mem_data),
    .ir_o        (ir),
    .unit_start_o(unit_start),
    .unit_done_i (unit_done),
    .pc_inc_i    (pc_inc),
    .busy_o      (busy),
    .halted_o    (halted),
    .fault_o     (fault),
    .fault_code_o(fault_code)
`ifdef DISPATCH_PERF_EN
    ,
    .retired_cnt_o(retired_cnt),
    .stall_max_o  (stall_max)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  int          cyc = 0;
  int          rd_cnt, start_cnt, last_rd_cyc, last_start_cyc, done_cyc;
  logic [7:0]  last_rd_addr;
  logic [3:0]  last_start;

  // Unit model configuration: cycle offsets after the start pulse (0 = never).
  int          m_inc_a, m_inc_b, m_inc_c, m_done_at;
  logic        m_wrong;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns data in the cycle after mem_rd; monitor logs strobes.
  initial begin
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        mem_data     = mem[mem_addr];
        rd_cnt       = rd_cnt + 1;
        last_rd_cyc  = cyc;
        last_rd_addr = mem_addr;
      end
      if (unit_start != 4'b0) begin
        start_cnt      = start_cnt + 1;
        last_start     = unit_start;
        last_start_cyc = cyc;
      end
    end
  end

  initial begin
    int idx;
    int tgt;
    unit_done = '0;
    pc_inc    = '0;
    forever begin
      @(negedge clk);
      unit_done = '0;
      pc_inc    = '0;
      if (unit_start != 4'b0 && reset) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (unit_start[i]) idx = i;
        tgt = m_wrong ? 2 : idx;
        for (int k = 1; k <= 40; k++) begin
          @(negedge clk);
          unit_done = '0;
          pc_inc    = '0;
          if (!reset) break;
          if (k == m_inc_a || k == m_inc_b || k == m_inc_c) pc_inc[tgt] = 1'b1;
          if (k == m_done_at) begin
            unit_done[tgt] = 1'b1;
            done_cyc       = cyc;
            if (!m_wrong) break;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    run       = 1'b0;
    m_inc_a   = 0;
    m_inc_b   = 0;
    m_inc_c   = 0;
    m_done_at = 0;
    m_wrong   = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 16'hF000;
    tick();
    tick();
    rd_cnt    = 0;
    start_cnt = 0;
    reset     = 1'b1;
  endtask

  task automatic wait_terminal(input int budget, input string name);
    for (int i = 0; i < budget && !(halted || fault); i++) tick();
    if (!(halted || fault)) begin
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for halt/fault, got busy=%b required terminal", name,
               busy);
    end
  endtask

  task automatic wait_start(input int n, input int budget, input string name);
    for (int i = 0; i < budget && start_cnt < n; i++) tick();
    if (start_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL %s: start pulse %0d never seen, got %0d pulses", name, n, start_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if ({mem_rd, unit_start, busy, halted, fault} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {mem_rd, unit_start, busy, halted, fault});
    end
    checks++;
    if ({mem_addr, ir, fault_code} !== 26'b0) begin
      errors++;
      $display("FAIL reset_regs: got pc=%h ir=%h fc=%b required all 0", mem_addr, ir, fault_code);
    end
`ifdef DISPATCH_PERF_EN
    checks++;
    if ({retired_cnt, stall_max} !== 24'b0) begin
      errors++;
      $display("FAIL reset_perf: got %h/%h required 0/0", retired_cnt, stall_max);
    end
`endif
  endtask

  task automatic test_program();
    do_reset();
    mem[0] = 16'h0123;
    mem[1] = 16'h1000;
    mem[2] = 16'hF000;
    m_inc_a   = 6;
    m_done_at = 7;
    run = 1'b1;
    wait_start(1, 20, "prog_start0");
    checks++;
    if (last_start !== 4'b0001 || ir !== 16'h0123) begin
      errors++;
      $display("FAIL prog_first: got start=%b ir=%h required 0001/0123", last_start, ir);
    end
    checks++;
    if (last_start_cyc - last_rd_cyc !== 3) begin
      errors++;
      $display("FAIL fetch_to_start: got %0d required 3", last_start_cyc - last_rd_cyc);
    end
    wait_start(2, 30, "prog_start1");
    checks++;
    if (last_start !== 4'b0010 || mem_addr !== 8'd1) begin
      errors++;
      $display("FAIL prog_second: got start=%b pc=%h required 0010/01", last_start, mem_addr);
    end
    checks++;
    if (last_rd_cyc - done_cyc !== 2) begin
      errors++;
      $display("FAIL done_to_rd: got %0d required 2", last_rd_cyc - done_cyc);
    end
    wait_terminal(40, "prog_halt");
    checks++;
    if ({halted, fault, busy} !== 3'b100 || mem_addr !== 8'd2 || ir !== 16'hF000) begin
      errors++;
      $display("FAIL prog_halt: got h/f/b=%b pc=%h ir=%h required 100/02/F000",
               {halted, fault, busy}, mem_addr, ir);
    end
    checks++;
    if (start_cnt !== 2) begin
      errors++;
      $display("FAIL prog_starts: got %0d required 2", start_cnt);
    end
`ifdef DISPATCH_PERF_EN
    checks++;
    if (retired_cnt !== 16'd2 || stall_max !== 8'd6) begin
      errors++;
      $display("FAIL prog_perf: got %0d/%0d required 2/6", retired_cnt, stall_max);
    end
`endif
  endtask

  task automatic test_pc_rules();
    int inc_a [3] = '{0, 2, 3};
    int inc_b [3] = '{0, 3, 0};
    int inc_c [3] = '{0, 4, 0};
    int done  [3] = '{4, 5, 3};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      mem[0]    = 16'h2000;
      m_inc_a   = inc_a[t];
      m_inc_b   = inc_b[t];
      m_inc_c   = inc_c[t];
      m_done_at = done[t];
      run       = 1'b1;
      wait_terminal(40, "pc_rule_run");
      checks++;
      if (halted !== 1'b1 || mem_addr !== 8'd1) begin
        errors++;
        $display("FAIL pc_rule_%0d: got halted=%b pc=%h required 1/01", t, halted, mem_addr);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    mem[0] = 16'h7000;
    run    = 1'b1;
    wait_terminal(20, "illegal_run");
    checks++;
    if ({fault, fault_code, halted, busy} !== 5'b10100) begin
      errors++;
      $display("FAIL illegal_flags: got f/fc/h/b=%b required 10100",
               {fault, fault_code, halted, busy});
    end
    checks++;
    if (start_cnt !== 0 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL illegal_side: got starts=%0d pc=%h required 0/00", start_cnt, mem_addr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem[0] = 16'h0000;
    run    = 1'b1;
    wait_start(1, 20, "to_start");
    repeat (32) tick();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got fault=%b required 0 after 31 waits", fault);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL timeout_fault: got f=%b fc=%b pc=%h required 1/10/00", fault, fault_code,
               mem_addr);
    end

    do_reset();
    mem[0]    = 16'h0000;
    mem[1]    = 16'hF000;
    m_done_at = 32;
    run       = 1'b1;
    wait_terminal(60, "to_edge_run");
    checks++;
    if ({halted, fault} !== 2'b10 || mem_addr !== 8'd1) begin
      errors++;
      $display("FAIL timeout_done_wins: got h/f=%b pc=%h required 10/01", {halted, fault},
               mem_addr);
    end
`ifdef DISPATCH_PERF_EN
    checks++;
    if (stall_max !== 8'd31) begin
      errors++;
      $display("FAIL stall_max_edge: got %0d required 31", stall_max);
    end
`endif

    do_reset();
    mem[0]    = 16'h0000;
    m_wrong   = 1'b1;
    m_inc_a   = 5;
    m_done_at = 7;
    run       = 1'b1;
    wait_terminal(60, "to_wrong_run");
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL wrong_unit: got f=%b fc=%b pc=%h required 1/10/00", fault, fault_code,
               mem_addr);
    end
  endtask

  task automatic test_run_drop_and_reset();
    do_reset();
    mem[0]    = 16'h0000;
    mem[1]    = 16'h0000;
    m_inc_a   = 6;
    m_done_at = 7;
    run       = 1'b1;
    wait_start(1, 20, "drop_start");
    tick();
    run = 1'b0;
    repeat (15) tick();
    checks++;
    if (rd_cnt !== 1 || busy !== 1'b0 || mem_addr !== 8'd1 || {halted, fault} !== 2'b00) begin
      errors++;
      $display("FAIL run_drop: got rd=%0d busy=%b pc=%h h/f=%b required 1/0/01/00", rd_cnt, busy,
               mem_addr, {halted, fault});
    end
`ifdef DISPATCH_PERF_EN
    checks++;
    if (retired_cnt !== 16'd1) begin
      errors++;
      $display("FAIL run_drop_retired: got %0d required 1", retired_cnt);
    end
`endif

    do_reset();
    mem[0]  = 16'h0000;
    m_inc_a = 2;
    run     = 1'b1;
    wait_start(1, 20, "rst_wait_start");
    repeat (4) tick();
    checks++;
    if (mem_addr !== 8'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_pre: got pc=%h busy=%b required 01/1", mem_addr, busy);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({mem_rd, unit_start, busy, halted, fault, fault_code} !== 10'b0 ||
        mem_addr !== 8'd0 || ir !== 16'd0) begin
      errors++;
      $display("FAIL rst_wait: got ctl=%b pc=%h ir=%h required 0/00/0000",
               {mem_rd, unit_start, busy, halted, fault, fault_code}, mem_addr, ir);
    end
    run   = 1'b0;
    reset = 1'b1;

    do_reset();
    mem[0] = 16'h3000;
    run    = 1'b1;
    wait_start(1, 20, "rst_start_start");
    checks++;
    if (unit_start !== 4'b1000) begin
      errors++;
      $display("FAIL rst_start_pre: got %b required 1000", unit_start);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (unit_start !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start: got start=%b busy=%b required 0000/0", unit_start, busy);
    end
    run   = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    m_done_at = 1;
    run       = 1'b1;
    for (int i = 0; i < 3000 && !(rd_cnt > 0 && last_rd_addr == 8'hFF); i++) tick();
    n = rd_cnt;
    for (int i = 0; i < 40 && rd_cnt == n; i++) tick();
    run = 1'b0;
    checks++;
    if (rd_cnt !== n + 1 || last_rd_addr !== 8'h00 || n !== 256) begin
      errors++;
      $display("FAIL pc_wrap: got fetches=%0d next_addr=%h required 257/00", rd_cnt,
               last_rd_addr);
    end
    repeat (12) tick();
  endtask

  task automatic test_perf();
    do_reset();
    mem[0]    = 16'h0000;
    mem[1]    = 16'h1000;
    mem[2]    = 16'h2000;
    mem[3]    = 16'hF000;
    m_inc_a   = 6;
    m_done_at = 7;
    run       = 1'b1;
    wait_terminal(80, "perf_run");
    checks++;
    if (halted !== 1'b1 || mem_addr !== 8'd3) begin
      errors++;
      $display("FAIL perf_prog: got halted=%b pc=%h required 1/03", halted, mem_addr);
    end
`ifdef DISPATCH_PERF_EN
    checks++;
    if (retired_cnt !== 16'd3) begin
      errors++;
      $display("FAIL retired_cnt: got %0d required 3", retired_cnt);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    test_reset();
    test_program();
    test_pc_rules();
    test_illegal();
    test_timeout();
    test_run_drop_and_reset();
    test_wrap();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
